sha3_sponge_ctrl: RTL and testbench
===================================

# sha3_sponge_ctrl

Sponge sequencer for the SHA-3 core. It accepts a message as an AXI-Stream of DATA_WIDTH words and drives lane-XOR writes into the 1600-bit Keccak state. It pads the message and steps the round counter through each 24-round permutation. After the final permutation it holds the squeeze stage's Ready/TUSER/Mode inputs until that stage reports Last, then re-arms for the next message.

## Interface
- DATA_WIDTH, 16, stream word width in bits; legal values 8/16/32/64.
- ROUNDS, 24, Keccak-f rounds per permutation.
- ACLK  in  1  clock; all logic on its rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- s_tdata  in  DATA_WIDTH  message word; byte 0 occupies bits [7:0].
- s_tvalid / s_tready  in / out  1  input handshake.
- s_tlast  in  1  final word of the message.
- s_tuser  in  2  variant: 0=224, 1=256, 2=384, 3=512; sampled on the first beat only.
- lite_mode  in  1  static; forwarded as sq_mode.
- state_clr  out  1  one-cycle pulse; zeroes the Keccak state.
- absorb_we  out  1  XOR absorb_data into word absorb_idx of the state.
- absorb_idx  out  8  word index within the rate.
- absorb_data  out  DATA_WIDTH  word to XOR.
- round_en  out  1  core performs one round this cycle.
- round_idx  out  5  round number, 0..ROUNDS-1.
- sq_ready, sq_tuser[1:0], sq_mode  out  drive the squeeze stage's Ready, TUSER and Mode.
- sq_last  in  1  squeeze stage Last.
- busy  out  1  state is not IDLE.

## Operation
- Rate in words: RW = R/DATA_WIDTH, with R = 1152, 1088, 832, 576 for tuser 0..3. Latched as `rw` on the first beat.
- FSM states: IDLE, CLEAR, ABSORB, PAD, PERMUTE, SQUEEZE. Counters: `wcnt` (8 bit, word index), `rcnt` (5 bit, round index). Flags: `last_seen`, `pad_done`.
- IDLE:
  - s_tready=0.
  - On s_tvalid=1: latch s_tuser, pulse state_clr, go to CLEAR.
- CLEAR: one cycle; wcnt=0; go to ABSORB.
- ABSORB:
  - s_tready=1.
  - Each accepted beat produces absorb_we=1, absorb_idx=wcnt, absorb_data=s_tdata, then wcnt++.
  - Accepted beat with wcnt=rw-1: go to PERMUTE and set `last_seen` if s_tlast=1.
  - Accepted s_tlast beat with wcnt<rw-1: set `last_seen`, go to PAD.
- PAD:
  - s_tready=0. Emits one write per cycle for wcnt..rw-1.
  - First pad word = domain byte D in byte 0. Every later word = 0.
  - Word rw-1 additionally has bit DATA_WIDTH-1 set, so a single pad word is D | 0x80<<(DATA_WIDTH-8).
  - After word rw-1: set `pad_done`, go to PERMUTE.
- PERMUTE:
  - round_en=1, round_idx=rcnt, rcnt 0→ROUNDS-1.
  - At rcnt=ROUNDS-1: if pad_done, go to SQUEEZE.
  - Else if last_seen (message ended exactly on a block boundary): wcnt=0, go to PAD; this emits a full pad block.
  - Else: wcnt=0, go to ABSORB.
- SQUEEZE:
  - sq_ready=1, sq_tuser=latched tuser, sq_mode=lite_mode.
  - On sq_last=1: drop sq_ready next cycle, clear flags, go to IDLE.
- absorb_we, round_en and state_clr are mutually exclusive.
- s_tuser is ignored after the first beat.
- Reset, asynchronous, at any time:
  - FSM goes to IDLE.
  - All outputs, counters and flags go to 0 immediately.
  - A partial message is discarded; the stream source must restart it.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Absorb throughput: 1 word/cycle while s_tvalid=1. s_tvalid gaps stall wcnt without side effects.
- s_tready=0 in IDLE, CLEAR, PAD, PERMUTE and SQUEEZE.
- Permutation: exactly ROUNDS consecutive round_en cycles. Absorb or pad resumes the following cycle.
- Single-block message of k<RW words: 2 cycles (IDLE→CLEAR→ABSORB) + k + (RW-k) pad + 24 until sq_ready=1.
- sq_ready stays high at least until sq_last is seen, and for exactly 1 cycle after it.

## Configuration
- SHA3_KECCAK_PAD_EN:
  - Defined: D=0x01 (original Keccak padding).
  - Undefined: D=0x06 (FIPS 202 SHA-3).
  - No other behaviour changes.

## Test plan
All scenarios use DATA_WIDTH=64 and the default (FIPS 202) padding unless stated.
- tuser=1, one word 0x0123456789ABCDEF with tlast → writes idx0=0x0123456789ABCDEF, idx1=0x06, idx2..15=0, idx16=0x8000000000000000. Then 24 round_en cycles with round_idx 0..23, then sq_ready=1 with sq_tuser=1.
- tuser=1, 17 words, tlast on word 17 → first permute, then a pad block idx0=0x06, idx16=0x8000000000000000, second permute. 48 round_en cycles total before sq_ready.
- tuser=3, 8 words → one pad write: idx8=0x8000000000000006.
- tuser=0, 40 words with random s_tvalid gaps → s_tready=0 for exactly 24 cycles after word 18. Second block resumes at idx0. Exactly 3 permutations before sq_ready.
- ARESETN low at round_idx=10 → all outputs 0 immediately, busy=0, next message starts with state_clr. Same bench with SHA3_KECCAK_PAD_EN defined: scenario 1's idx1 becomes 0x01.
- tuser changed from 1 to 3 mid-message → rate remains 17 words and sq_tuser=1.

Source files
------------

// File: rtl/sha3_sponge_ctrl.sv
// sha3_sponge_ctrl: sponge sequencer in front of a Keccak-f[1600] core.
// Absorbs an AXI-Stream message as lane-XOR writes, applies multi-rate
// padding, runs ROUNDS-round permutations and then holds the squeeze stage
// until it reports Last.
//
// Build option:
//   SHA3_KECCAK_PAD_EN  defined   -> domain byte 0x01 (original Keccak)
//                       undefined -> domain byte 0x06 (FIPS 202 SHA-3)
//
// State table (state | meaning):
//   IDLE    | waiting for the first beat of a message; no handshake
//   CLEAR   | state_clr pulse is on the bus; word counter rewinds
//   ABSORB  | accepting words, one XOR write per accepted beat
//   PAD     | emitting pad words up to the end of the rate block
//   PERMUTE | issuing ROUNDS consecutive round_en cycles
//   SQUEEZE | holding sq_ready/sq_tuser/sq_mode until sq_last
//
// Every output is a register. A write or round issued by a state becomes
// visible the cycle after it is issued, so the last absorb/pad write of a
// block lands in the first PERMUTE cycle and the first round follows it.

module sha3_sponge_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ROUNDS     = 24
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [1:0]            s_tuser,
    input  logic                  lite_mode,
    output logic                  state_clr,
    output logic                  absorb_we,
    output logic [7:0]            absorb_idx,
    output logic [DATA_WIDTH-1:0] absorb_data,
    output logic                  round_en,
    output logic [4:0]            round_idx,
    output logic                  sq_ready,
    output logic [1:0]            sq_tuser,
    output logic                  sq_mode,
    input  logic                  sq_last,
    output logic                  busy
);

`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`endif

    // First pad word carries the domain byte in byte 0; the last word of the
    // rate block carries the closing 1 bit in its top bit.
    localparam logic [DATA_WIDTH-1:0] PAD_FIRST = DATA_WIDTH'(DOMAIN_BYTE);
    localparam logic [DATA_WIDTH-1:0] PAD_LAST  = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Rate in stream words for each variant (224/256/384/512).
    localparam logic [7:0] RW_224 = 8'(1152 / DATA_WIDTH);
    localparam logic [7:0] RW_256 = 8'(1088 / DATA_WIDTH);
    localparam logic [7:0] RW_384 = 8'(832 / DATA_WIDTH);
    localparam logic [7:0] RW_512 = 8'(576 / DATA_WIDTH);

    localparam logic [4:0] RCNT_LAST = 5'(ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ABSORB  = 3'd2,
        PAD     = 3'd3,
        PERMUTE = 3'd4,
        SQUEEZE = 3'd5
    } state_t;

    state_t     state;
    logic [7:0] wcnt;
    logic [7:0] rw;
    logic [7:0] rw_last;
    logic [4:0] rcnt;
    logic [1:0] tuser_q;
    logic       last_seen;
    logic       pad_done;
    logic       pad_first;
    logic       accept;
    logic       at_block_end;

    function automatic logic [7:0] rate_words(input logic [1:0] variant);
        logic [7:0] words;
        case (variant)
            2'd0:    words = RW_224;
            2'd1:    words = RW_256;
            2'd2:    words = RW_384;
            default: words = RW_512;
        endcase
        return words;
    endfunction

    assign accept       = s_tvalid & s_tready;
    assign rw_last      = rw - 8'd1;
    assign at_block_end = (wcnt == rw_last);

    // Sponge sequencer: state, counters, flags and every registered output.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state       <= IDLE;
            wcnt        <= 8'd0;
            rw          <= 8'd0;
            rcnt        <= 5'd0;
            tuser_q     <= 2'd0;
            last_seen   <= 1'b0;
            pad_done    <= 1'b0;
            pad_first   <= 1'b0;
            s_tready    <= 1'b0;
            state_clr   <= 1'b0;
            absorb_we   <= 1'b0;
            absorb_idx  <= 8'd0;
            absorb_data <= '0;
            round_en    <= 1'b0;
            round_idx   <= 5'd0;
            sq_ready    <= 1'b0;
            sq_tuser    <= 2'd0;
            sq_mode     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a state re-asserts them.
            state_clr <= 1'b0;
            absorb_we <= 1'b0;
            round_en  <= 1'b0;

            case (state)
                IDLE: begin
                    s_tready <= 1'b0;
                    sq_ready <= 1'b0;
                    sq_tuser <= 2'd0;
                    sq_mode  <= 1'b0;
                    if (s_tvalid) begin
                        // Variant is taken from the first beat only; the beat
                        // itself is accepted later in ABSORB.
                        tuser_q   <= s_tuser;
                        rw        <= rate_words(s_tuser);
                        state_clr <= 1'b1;
                        busy      <= 1'b1;
                        state     <= CLEAR;
                    end
                end

                CLEAR: begin
                    wcnt      <= 8'd0;
                    rcnt      <= 5'd0;
                    last_seen <= 1'b0;
                    pad_done  <= 1'b0;
                    pad_first <= 1'b0;
                    s_tready  <= 1'b1;
                    state     <= ABSORB;
                end

                ABSORB: begin
                    if (accept) begin
                        absorb_we   <= 1'b1;
                        absorb_idx  <= wcnt;
                        absorb_data <= s_tdata;
                        if (at_block_end) begin
                            // Block full; a tlast here means a whole pad
                            // block follows this permutation.
                            s_tready  <= 1'b0;
                            last_seen <= s_tlast;
                            rcnt      <= 5'd0;
                            state     <= PERMUTE;
                        end else if (s_tlast) begin
                            s_tready  <= 1'b0;
                            last_seen <= 1'b1;
                            pad_first <= 1'b1;
                            wcnt      <= wcnt + 8'd1;
                            state     <= PAD;
                        end else begin
                            wcnt <= wcnt + 8'd1;
                        end
                    end
                end

                PAD: begin
                    absorb_we   <= 1'b1;
                    absorb_idx  <= wcnt;
                    absorb_data <= (pad_first    ? PAD_FIRST : '0) |
                                   (at_block_end ? PAD_LAST  : '0);
                    pad_first   <= 1'b0;
                    if (at_block_end) begin
                        pad_done <= 1'b1;
                        rcnt     <= 5'd0;
                        state    <= PERMUTE;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end

                PERMUTE: begin
                    round_en  <= 1'b1;
                    round_idx <= rcnt;
                    if (rcnt == RCNT_LAST) begin
                        rcnt <= 5'd0;
                        if (pad_done) begin
                            state <= SQUEEZE;
                        end else if (last_seen) begin
                            wcnt      <= 8'd0;
                            pad_first <= 1'b1;
                            state     <= PAD;
                        end else begin
                            // Re-open the stream so the next word can be
                            // taken while the final round is on the bus.
                            wcnt     <= 8'd0;
                            s_tready <= 1'b1;
                            state    <= ABSORB;
                        end
                    end else begin
                        rcnt <= rcnt + 5'd1;
                    end
                end

                SQUEEZE: begin
                    sq_ready <= 1'b1;
                    sq_tuser <= tuser_q;
                    sq_mode  <= lite_mode;
                    if (sq_ready && sq_last) begin
                        // sq_ready stays up one more cycle; IDLE drops it.
                        last_seen <= 1'b0;
                        pad_done  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    s_tready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed testbench for sha3_sponge_ctrl at DATA_WIDTH=64.
// Honors SHA3_KECCAK_PAD_EN for the expected domain byte.

module tb_sha3_sponge_ctrl;

    localparam int DW = 64;
    localparam logic [63:0] MSB = 64'h8000_0000_0000_0000;
`ifdef SHA3_KECCAK_PAD_EN
    localparam logic [63:0] DOM = 64'h01;
`else
    localparam logic [63:0] DOM = 64'h06;
`endif

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic          s_tlast = 1'b0;
    logic [1:0]    s_tuser = 2'd0;
    logic          lite_mode = 1'b1;
    logic          state_clr;
    logic          absorb_we;
    logic [7:0]    absorb_idx;
    logic [DW-1:0] absorb_data;
    logic          round_en;
    logic [4:0]    round_idx;
    logic          sq_ready;
    logic [1:0]    sq_tuser;
    logic          sq_mode;
    logic          sq_last = 1'b0;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_idx[$];
    logic [63:0] wr_data[$];
    logic [4:0]  rnd_log[$];
    int          clr_cnt = 0;
    int          excl_err = 0;

    sha3_sponge_ctrl #(.DATA_WIDTH(DW), .ROUNDS(24)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tlast(s_tlast), .s_tuser(s_tuser), .lite_mode(lite_mode),
        .state_clr(state_clr), .absorb_we(absorb_we), .absorb_idx(absorb_idx),
        .absorb_data(absorb_data), .round_en(round_en), .round_idx(round_idx),
        .sq_ready(sq_ready), .sq_tuser(sq_tuser), .sq_mode(sq_mode),
        .sq_last(sq_last), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    // Record strobes on the falling edge, away from the active edge.
    always @(negedge ACLK) begin
        if (ARESETN) begin
            if (absorb_we) begin
                wr_idx.push_back(absorb_idx);
                wr_data.push_back(absorb_data);
            end
            if (round_en) rnd_log.push_back(round_idx);
            if (state_clr) clr_cnt++;
            if (int'(absorb_we) + int'(round_en) + int'(state_clr) > 1) excl_err++;
        end
    end

    function automatic logic [63:0] word_of(input int i);
        return 64'hA5C3_0000_0000_0000 + 64'(i);
    endfunction

    task automatic clear_logs();
        wr_idx.delete();
        wr_data.delete();
        rnd_log.delete();
        clr_cnt = 0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last,
                             input logic [1:0] u, output int stall);
        s_tdata  = d;
        s_tlast  = last;
        s_tuser  = u;
        s_tvalid = 1'b1;
        stall    = 0;
        while (!s_tready && stall < 100) begin
            @(posedge ACLK); #1;
            stall++;
        end
        if (!s_tready) begin
            checks++; errors++;
            $display("FAIL beat_timeout tready still 0 after %0d cycles, want 1", stall);
        end
        @(posedge ACLK); #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_sq();
        int n;
        n = 0;
        while (!sq_ready && n < 500) begin
            @(posedge ACLK); #1;
            n++;
        end
        checks++;
        if (sq_ready !== 1'b1) begin
            errors++;
            $display("FAIL sq_ready_timeout got %b want 1 within 500 cycles", sq_ready);
        end
    endtask

    task automatic finish_squeeze();
        sq_last = 1'b1;
        @(posedge ACLK); #1;
        sq_last = 1'b0;
        @(posedge ACLK); #1;
    endtask

    task automatic do_reset();
        ARESETN  = 1'b0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        sq_last  = 1'b0;
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({s_tready, state_clr, absorb_we, round_en, sq_ready, sq_mode, busy} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000000",
                     {s_tready, state_clr, absorb_we, round_en, sq_ready, sq_mode, busy});
        end
        checks++;
        if (absorb_idx !== 8'd0 || absorb_data !== 64'd0 || round_idx !== 5'd0 || sq_tuser !== 2'd0) begin
            errors++;
            $display("FAIL reset_buses got idx=%0d data=%h ridx=%0d tuser=%0d want all 0",
                     absorb_idx, absorb_data, round_idx, sq_tuser);
        end
    endtask

    task automatic test_single_word();
        int st;
        clear_logs();
        send_beat(64'h0123456789ABCDEF, 1'b1, 2'd1, st);
        wait_sq();
        checks++;
        if (wr_idx.size() != 17) begin
            errors++;
            $display("FAIL single_wr_count got %0d want 17", wr_idx.size());
        end
        for (int i = 0; i < wr_idx.size() && i < 17; i++) begin
            logic [63:0] e;
            e = (i == 0) ? 64'h0123456789ABCDEF : (i == 1) ? DOM : (i == 16) ? MSB : 64'h0;
            checks++;
            if (wr_idx[i] !== 8'(i) || wr_data[i] !== e) begin
                errors++;
                $display("FAIL single_wr[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                         i, wr_idx[i], wr_data[i], i, e);
            end
        end
        checks++;
        if (rnd_log.size() != 24) begin
            errors++;
            $display("FAIL single_rounds got %0d want 24", rnd_log.size());
        end
        for (int i = 0; i < rnd_log.size(); i++) begin
            checks++;
            if (rnd_log[i] !== 5'(i % 24)) begin
                errors++;
                $display("FAIL single_round_idx[%0d] got %0d want %0d", i, rnd_log[i], i % 24);
            end
        end
        checks++;
        if (clr_cnt != 1) begin
            errors++;
            $display("FAIL single_clr got %0d pulses want 1", clr_cnt);
        end
        checks++;
        if (sq_tuser !== 2'd1 || sq_mode !== 1'b1 || busy !== 1'b1 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL single_squeeze got tuser=%0d mode=%b busy=%b tready=%b want 1 1 1 0",
                     sq_tuser, sq_mode, busy, s_tready);
        end
        sq_last = 1'b1;
        @(posedge ACLK); #1;
        sq_last = 1'b0;
        checks++;
        if (sq_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL sq_hold got ready=%b busy=%b want ready=1 busy=0", sq_ready, busy);
        end
        @(posedge ACLK); #1;
        checks++;
        if (sq_ready !== 1'b0) begin
            errors++;
            $display("FAIL sq_drop got ready=%b want 0", sq_ready);
        end
    endtask

    task automatic test_block_boundary();
        int st;
        clear_logs();
        for (int i = 0; i < 17; i++) send_beat(word_of(i), (i == 16), 2'd1, st);
        wait_sq();
        checks++;
        if (wr_idx.size() != 34) begin
            errors++;
            $display("FAIL boundary_wr_count got %0d want 34", wr_idx.size());
        end
        for (int i = 0; i < wr_idx.size() && i < 34; i++) begin
            logic [63:0] e;
            int          k;
            k = i % 17;
            e = (i < 17) ? word_of(i) : (k == 0) ? DOM : (k == 16) ? MSB : 64'h0;
            checks++;
            if (wr_idx[i] !== 8'(k) || wr_data[i] !== e) begin
                errors++;
                $display("FAIL boundary_wr[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                         i, wr_idx[i], wr_data[i], k, e);
            end
        end
        checks++;
        if (rnd_log.size() != 48) begin
            errors++;
            $display("FAIL boundary_rounds got %0d want 48", rnd_log.size());
        end
        finish_squeeze();
    endtask

    task automatic test_single_pad();
        int st;
        clear_logs();
        for (int i = 0; i < 8; i++) send_beat(word_of(i), (i == 7), 2'd3, st);
        wait_sq();
        checks++;
        if (wr_idx.size() != 9) begin
            errors++;
            $display("FAIL onepad_wr_count got %0d want 9", wr_idx.size());
        end
        for (int i = 0; i < wr_idx.size() && i < 9; i++) begin
            logic [63:0] e;
            e = (i < 8) ? word_of(i) : (MSB | DOM);
            checks++;
            if (wr_idx[i] !== 8'(i) || wr_data[i] !== e) begin
                errors++;
                $display("FAIL onepad_wr[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                         i, wr_idx[i], wr_data[i], i, e);
            end
        end
        checks++;
        if (rnd_log.size() != 24 || sq_tuser !== 2'd3) begin
            errors++;
            $display("FAIL onepad_end got rounds=%0d tuser=%0d want 24 3", rnd_log.size(), sq_tuser);
        end
        finish_squeeze();
    endtask

    task automatic test_gaps();
        int st;
        int gap;
        clear_logs();
        for (int i = 0; i < 40; i++) begin
            if (i != 18 && i != 36) begin
                gap = int'($urandom_range(0, 2));
                repeat (gap) begin @(posedge ACLK); #1; end
            end
            send_beat(word_of(i), (i == 39), 2'd0, st);
            if (i == 18 || i == 36) begin
                checks++;
                if (st != 24) begin
                    errors++;
                    $display("FAIL gaps_stall word %0d got %0d cycles want 24", i + 1, st);
                end
            end
        end
        wait_sq();
        checks++;
        if (wr_idx.size() != 54) begin
            errors++;
            $display("FAIL gaps_wr_count got %0d want 54", wr_idx.size());
        end
        for (int i = 0; i < wr_idx.size() && i < 54; i++) begin
            logic [63:0] e;
            int          k;
            if (i < 40) begin
                k = i % 18;
                e = word_of(i);
            end else begin
                k = i - 36;
                e = (k == 4) ? DOM : (k == 17) ? MSB : 64'h0;
            end
            checks++;
            if (wr_idx[i] !== 8'(k) || wr_data[i] !== e) begin
                errors++;
                $display("FAIL gaps_wr[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                         i, wr_idx[i], wr_data[i], k, e);
            end
        end
        checks++;
        if (rnd_log.size() != 72) begin
            errors++;
            $display("FAIL gaps_rounds got %0d want 72", rnd_log.size());
        end
        for (int i = 0; i < rnd_log.size(); i++) begin
            checks++;
            if (rnd_log[i] !== 5'(i % 24)) begin
                errors++;
                $display("FAIL gaps_round_idx[%0d] got %0d want %0d", i, rnd_log[i], i % 24);
            end
        end
        finish_squeeze();
    endtask

    task automatic test_reset_mid();
        int st;
        int n;
        clear_logs();
        send_beat(64'h0123456789ABCDEF, 1'b1, 2'd1, st);
        n = 0;
        while (!(round_en && round_idx == 5'd10) && n < 200) begin
            @(posedge ACLK); #1;
            n++;
        end
        checks++;
        if (!(round_en && round_idx == 5'd10)) begin
            errors++;
            $display("FAIL rst_mid_wait round_idx=%0d round_en=%b want 10 1", round_idx, round_en);
        end
        #2;
        ARESETN = 1'b0;
        #1;
        checks++;
        if ({s_tready, state_clr, absorb_we, round_en, sq_ready, busy} !== 6'b0 ||
            round_idx !== 5'd0 || absorb_idx !== 8'd0 || absorb_data !== 64'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs got flags=%b ridx=%0d idx=%0d data=%h want all 0",
                     {s_tready, state_clr, absorb_we, round_en, sq_ready, busy},
                     round_idx, absorb_idx, absorb_data);
        end
        @(posedge ACLK); #1;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_busy got %b want 0", busy);
        end
        clear_logs();
        send_beat(64'h0123456789ABCDEF, 1'b1, 2'd1, st);
        wait_sq();
        checks++;
        if (clr_cnt != 1 || wr_idx.size() != 17) begin
            errors++;
            $display("FAIL rst_restart got clr=%0d writes=%0d want 1 17", clr_cnt, wr_idx.size());
        end else begin
            checks++;
            if (wr_idx[0] !== 8'd0 || wr_data[0] !== 64'h0123456789ABCDEF || wr_data[1] !== DOM) begin
                errors++;
                $display("FAIL rst_restart_data got idx0=%0d d0=%h d1=%h want 0 0123456789abcdef %h",
                         wr_idx[0], wr_data[0], wr_data[1], DOM);
            end
        end
        finish_squeeze();
    endtask

    task automatic test_tuser_change();
        int st;
        clear_logs();
        for (int i = 0; i < 5; i++) send_beat(word_of(i), (i == 4), (i == 0) ? 2'd1 : 2'd3, st);
        wait_sq();
        checks++;
        if (wr_idx.size() != 17) begin
            errors++;
            $display("FAIL tuser_wr_count got %0d want 17", wr_idx.size());
        end
        for (int i = 0; i < wr_idx.size() && i < 17; i++) begin
            logic [63:0] e;
            e = (i < 5) ? word_of(i) : (i == 5) ? DOM : (i == 16) ? MSB : 64'h0;
            checks++;
            if (wr_idx[i] !== 8'(i) || wr_data[i] !== e) begin
                errors++;
                $display("FAIL tuser_wr[%0d] got idx=%0d data=%h want idx=%0d data=%h",
                         i, wr_idx[i], wr_data[i], i, e);
            end
        end
        checks++;
        if (sq_tuser !== 2'd1) begin
            errors++;
            $display("FAIL tuser_sq got %0d want 1", sq_tuser);
        end
        finish_squeeze();
    endtask

    task automatic test_exclusive();
        checks++;
        if (excl_err != 0) begin
            errors++;
            $display("FAIL strobe_exclusive got %0d overlapping cycles want 0", excl_err);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_block_boundary();
        test_single_pad();
        test_gaps();
        test_reset_mid();
        test_tuser_change();
        test_exclusive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
